traffic_phase_ctrl: RTL and testbench

Phase sequencer for the intersection. It consumes the one-second tick from the clock divider and drives the main-street lamps, side-street lamps and pedestrian walk lamp. A side-street car sensor and a pedestrian button request service. Main street rests on green until a request arrives and its minimum green time has elapsed.

---
 rtl/traffic_phase_ctrl_if.sv | 22 ++
 rtl/traffic_phase_ctrl.sv | 111 +++++++++++
 tb/tb_traffic_phase_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/request bundle between the intersection sequencer and its surroundings.
// Requests are plain levels sampled on each clock edge; lamp outputs are registered decodes.
interface traffic_phase_ctrl_if;
    logic       tick_1s;
    logic       sensor;
    logic       walk_req;
    logic [2:0] main_lt;
    logic [2:0] side_lt;
    logic       walk;
    logic [2:0] phase;
    logic       walk_pend;

    modport master (
        output tick_1s, sensor, walk_req,
        input  main_lt, side_lt, walk, phase, walk_pend
    );

    modport slave (
        input  tick_1s, sensor, walk_req,
        output main_lt, side_lt, walk, phase, walk_pend
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: main green rests until a side car or pedestrian
// request arrives, then cycles through yellow, walk and side phases on 1 s ticks.
module traffic_phase_ctrl #(
    parameter int MAIN_GREEN_S = 10,
    parameter int SIDE_GREEN_S = 6,
    parameter int YELLOW_S     = 3,
    parameter int WALK_S       = 4,
    parameter int CNT_W        = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    traffic_phase_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        MG = 3'd0,
        MY = 3'd1,
        SG = 3'd2,
        SY = 3'd3,
        WK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MG_MIN  = CNT_W'(MAIN_GREEN_S);
    localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN_S - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] WK_LAST = CNT_W'(WALK_S - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic             walk_pend_q, walk_pend_d;
    logic             expired;
    logic [2:0]       main_lt_c, side_lt_c;
    logic             walk_c;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= MG;
            sec_cnt_q   <= '0;
            walk_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            walk_pend_q <= walk_pend_d;
        end
    end

    // A timed state expires on the tick that completes its last second.
    always_comb begin
        expired = 1'b0;
        case (state_q)
            MY, SY:  expired = bus.tick_1s && (sec_cnt_q == Y_LAST);
            SG:      expired = bus.tick_1s && (sec_cnt_q == SG_LAST);
            WK:      expired = bus.tick_1s && (sec_cnt_q == WK_LAST);
            default: expired = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MG: if ((sec_cnt_q >= MG_MIN) && (bus.sensor || walk_pend_q)) state_d = MY;
            MY: if (expired) state_d = walk_pend_q ? WK : SG;
            SG: if (expired) state_d = SY;
            SY: if (expired) state_d = MG;
            WK: if (expired) state_d = bus.sensor ? SG : MG;
            default: state_d = MG;
        endcase
    end

    // Entering WK absorbs any request, including one raised on the entry edge.
    always_comb begin
        walk_pend_d = walk_pend_q;
        if (state_q != WK) begin
            if (state_d == WK)
                walk_pend_d = 1'b0;
            else if (bus.walk_req)
                walk_pend_d = 1'b1;
        end
    end

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        if (state_d != state_q)
            sec_cnt_d = '0;
        else if (bus.tick_1s && (sec_cnt_q != CNT_MAX))
            sec_cnt_d = sec_cnt_q + 1'b1;
    end

    // Unknown codes show all-red until the state register recovers to MG.
    always_comb begin
        main_lt_c = 3'b100;
        side_lt_c = 3'b100;
        walk_c    = 1'b0;
        case (state_q)
            MG:      main_lt_c = 3'b001;
            MY:      main_lt_c = 3'b010;
            SG:      side_lt_c = 3'b001;
            SY:      side_lt_c = 3'b010;
            WK:      walk_c    = 1'b1;
            default: walk_c    = 1'b0;
        endcase
    end

    assign bus.main_lt   = main_lt_c;
    assign bus.side_lt   = side_lt_c;
    assign bus.walk      = walk_c;
    assign bus.phase     = state_q;
    assign bus.walk_pend = walk_pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a default-timed instance under directed and random
// stimulus, plus an all-durations-one instance under random stimulus.
module tb_traffic_phase_ctrl;

    logic clock;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    traffic_phase_ctrl_if if_m ();
    traffic_phase_ctrl_if if_f ();

    traffic_phase_ctrl u_dut (
        .clock (clock),
        .rst   (rst),
        .bus   (if_m)
    );

    traffic_phase_ctrl #(
        .MAIN_GREEN_S (1),
        .SIDE_GREEN_S (1),
        .YELLOW_S     (1),
        .WALK_S       (1),
        .CNT_W        (8)
    ) u_fast (
        .clock (clock),
        .rst   (rst),
        .bus   (if_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: MG tracks elapsed seconds (capped); timed phases count seconds remaining.
    typedef struct {
        int ph;
        int elapsed;
        int left;
        bit pend;
    } model_t;

    localparam logic [2:0] MAIN_TAB [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] SIDE_TAB [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    model_t mod_m, mod_f;

    function automatic model_t model_reset();
        model_t r;
        r.ph = 0; r.elapsed = 0; r.left = 0; r.pend = 1'b0;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input bit tick, input bit sen, input bit wreq,
                                    input int d_mg, input int d_sg, input int d_y, input int d_wk);
        model_t n = m;
        int nxt = m.ph;
        if (m.ph == 0) begin
            if (m.elapsed >= d_mg && (sen || m.pend)) nxt = 1;
        end else if (tick && m.left == 1) begin
            case (m.ph)
                1: nxt = m.pend ? 4 : 2;
                2: nxt = 3;
                3: nxt = 0;
                default: nxt = sen ? 2 : 0;
            endcase
        end
        if (m.ph != 4) begin
            if (nxt == 4) n.pend = 1'b0;
            else if (wreq) n.pend = 1'b1;
        end
        if (nxt != m.ph) begin
            n.ph = nxt;
            n.elapsed = 0;
            case (nxt)
                1, 3: n.left = d_y;
                2: n.left = d_sg;
                4: n.left = d_wk;
                default: n.left = 0;
            endcase
        end else if (tick) begin
            if (m.elapsed < 255) n.elapsed = m.elapsed + 1;
            if (m.left > 0) n.left = m.left - 1;
        end
        return n;
    endfunction

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            mod_m <= model_reset();
            mod_f <= model_reset();
        end else begin
            mod_m <= step(mod_m, if_m.tick_1s, if_m.sensor, if_m.walk_req, 10, 6, 3, 4);
            mod_f <= step(mod_f, if_f.tick_1s, if_f.sensor, if_f.walk_req, 1, 1, 1, 1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input string tag, input model_t m, input logic [2:0] main_lt,
                            input logic [2:0] side_lt, input logic walk, input logic [2:0] phase,
                            input logic walk_pend);
        chk({tag, " main_lt"}, int'(main_lt), int'(MAIN_TAB[m.ph]));
        chk({tag, " side_lt"}, int'(side_lt), int'(SIDE_TAB[m.ph]));
        chk({tag, " walk"}, int'(walk), (m.ph == 4) ? 1 : 0);
        chk({tag, " phase"}, int'(phase), m.ph);
        chk({tag, " walk_pend"}, int'(walk_pend), int'(m.pend));
        chk({tag, " both_non_red"}, int'((main_lt != 3'b100) && (side_lt != 3'b100)), 0);
        chk({tag, " phase_legal"}, int'(phase <= 3'd4), 1);
    endtask

    always @(negedge clock) begin
        if (rst) begin
            chk_inst("main", mod_m, if_m.main_lt, if_m.side_lt, if_m.walk, if_m.phase, if_m.walk_pend);
            chk_inst("fast", mod_f, if_f.main_lt, if_f.side_lt, if_f.walk, if_f.phase, if_f.walk_pend);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic lit(input string name, input int ph, input logic [2:0] ml, input logic [2:0] sl);
        chk({name, " phase"}, int'(if_m.phase), ph);
        chk({name, " main"}, int'(if_m.main_lt), int'(ml));
        chk({name, " side"}, int'(if_m.side_lt), int'(sl));
    endtask

    // The all-ones instance sees random inputs for the whole run.
    initial begin
        if_f.tick_1s = 1'b0; if_f.sensor = 1'b0; if_f.walk_req = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if_f.tick_1s  = ($urandom_range(0, 1) == 1);
            if_f.sensor   = ($urandom_range(0, 3) == 0);
            if_f.walk_req = ($urandom_range(0, 5) == 0);
        end
    end

    initial begin
        rst = 1'b0;
        if_m.tick_1s = 1'b1; if_m.sensor = 1'b1; if_m.walk_req = 1'b0;
        #1;
        chk("reset phase", int'(if_m.phase), 0);
        chk("reset main", int'(if_m.main_lt), 1);
        chk("reset side", int'(if_m.side_lt), 4);
        chk("reset walk_pend", int'(if_m.walk_pend), 0);

        // Side service with sensor held from reset, one tick per cycle.
        do_reset();
        edges(10); lit("svc mg_end", 0, 3'b001, 3'b100);
        edges(1);  lit("svc my", 1, 3'b010, 3'b100);
        edges(2);  lit("svc my_last", 1, 3'b010, 3'b100);
        edges(1);  lit("svc sg", 2, 3'b100, 3'b001);
        edges(5);  lit("svc sg_last", 2, 3'b100, 3'b001);
        edges(1);  lit("svc sy", 3, 3'b100, 3'b010);
        edges(3);  lit("svc back_mg", 0, 3'b001, 3'b100);

        // Pedestrian request, then a request held across WK entry and during WK.
        if_m.sensor = 1'b0;
        do_reset();
        edges(2);  if_m.walk_req = 1'b1;
        edges(1);  if_m.walk_req = 1'b0;
        chk("ped pend_set", int'(if_m.walk_pend), 1);
        edges(7);  lit("ped mg_hold", 0, 3'b001, 3'b100);
        edges(1);  lit("ped my", 1, 3'b010, 3'b100);
        edges(2);  if_m.walk_req = 1'b1;
        edges(1);  lit("ped wk", 4, 3'b100, 3'b100);
        chk("ped walk", int'(if_m.walk), 1);
        chk("ped pend_absorbed", int'(if_m.walk_pend), 0);
        edges(2);  chk("ped pend_in_wk", int'(if_m.walk_pend), 0);
        edges(1);  if_m.walk_req = 1'b0;
        edges(1);  lit("ped back_mg", 0, 3'b001, 3'b100);
        chk("ped pend_after", int'(if_m.walk_pend), 0);

        // Sensor and walk together: MY, WK, then SG since sensor stays high.
        if_m.sensor = 1'b1; if_m.walk_req = 1'b1;
        do_reset();
        edges(1);  if_m.walk_req = 1'b0;
        chk("both pend", int'(if_m.walk_pend), 1);
        edges(10); lit("both my", 1, 3'b010, 3'b100);
        edges(3);  lit("both wk", 4, 3'b100, 3'b100);
        edges(4);  lit("both sg", 2, 3'b100, 3'b001);

        // Asynchronous reset mid-SG with a walk request pending.
        edges(2);  if_m.walk_req = 1'b1;
        edges(1);  if_m.walk_req = 1'b0;
        chk("rst pend_before", int'(if_m.walk_pend), 1);
        #2 rst = 1'b0;
        #1;
        lit("rst mid_sg", 0, 3'b001, 3'b100);
        chk("rst walk", int'(if_m.walk), 0);
        chk("rst pend", int'(if_m.walk_pend), 0);

        // Idle hold past counter wrap; a late sensor must still exit at once.
        if_m.sensor = 1'b0;
        do_reset();
        edges(260); lit("idle hold", 0, 3'b001, 3'b100);
        if_m.sensor = 1'b1;
        edges(1);   lit("idle saturated_exit", 1, 3'b010, 3'b100);

        // Random traffic on the default instance.
        for (int i = 0; i < 9000; i++) begin
            @(negedge clock);
            #1;
            if_m.tick_1s  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) if_m.sensor = ~if_m.sensor;
            if_m.walk_req = ($urandom_range(0, 40) == 0);
        end
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
